uart_bus_master: RTL and testbench



---
 rtl/uart_bus_master_if.sv | 28 ++
 rtl/uart_bus_master.sv | 122 ++++++++++++
 tb/tb_uart_bus_master.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bus_master_if.sv
// Bundles the UART byte streams and the single-master data bus of uart_bus_master.
// Handshake: rx and tx bytes move on a cycle where valid && ready; tx_data is held
// while tx_valid is high. A bus transaction completes on the cycle bus_req && bus_ack.
interface uart_bus_master_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        busy;

    modport master (
        input  rx_data, rx_valid, tx_ready, bus_rdata, bus_ack,
        output rx_ready, tx_data, tx_valid, bus_req, bus_we, bus_addr, bus_wdata, busy
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, bus_rdata, bus_ack,
        input  rx_ready, tx_data, tx_valid, bus_req, bus_we, bus_addr, bus_wdata, busy
    );
endinterface

// File: rtl/uart_bus_master.sv
// UART-driven debug bus master: decodes 'W'/'R' commands from the rx byte stream,
// runs one bus transaction at a time and streams the response bytes back on tx.
module uart_bus_master #(
    parameter int         TIMEOUT  = 1024,
    parameter logic [7:0] ACK_BYTE = 8'h06,
    parameter logic [7:0] NAK_BYTE = 8'h15
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_bus_master_if.master       io,
    output logic [2:0]              state_dbg
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_WDATA = 3'd2;
    localparam logic [2:0] S_BUS   = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam int         TW       = $clog2(TIMEOUT + 1);

    logic [2:0]    state;
    logic          is_write;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [1:0]    rx_cnt;
    logic [31:0]   resp_data;
    logic [2:0]    resp_cnt;
    logic [TW-1:0] tout_cnt;
    logic          rx_fire;
    logic          tx_fire;

    // Outputs decode straight from the state register so reset clears them asynchronously.
    assign io.rx_ready  = (state == S_IDLE) || (state == S_ADDR) || (state == S_WDATA);
    assign io.tx_valid  = (state == S_RESP);
    assign io.tx_data   = resp_data[31:24];
    assign io.bus_req   = (state == S_BUS);
    assign io.bus_we    = is_write;
    assign io.bus_addr  = {addr[31:2], 2'b00};
    assign io.bus_wdata = wdata;
    assign io.busy      = (state != S_IDLE);
    assign state_dbg    = state;

    assign rx_fire = io.rx_valid && io.rx_ready;
    assign tx_fire = io.tx_valid && io.tx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            is_write  <= 1'b0;
            addr      <= 32'h0;
            wdata     <= 32'h0;
            rx_cnt    <= 2'd0;
            resp_data <= 32'h0;
            resp_cnt  <= 3'd0;
            tout_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_fire) begin
                        if (io.rx_data == OP_WRITE || io.rx_data == OP_READ) begin
                            is_write <= (io.rx_data == OP_WRITE);
                            rx_cnt   <= 2'd0;
                            state    <= S_ADDR;
                        end else begin
                            resp_data <= {NAK_BYTE, 24'h0};
                            resp_cnt  <= 3'd1;
                            state     <= S_RESP;
                        end
                    end
                end
                S_ADDR: begin
                    if (rx_fire) begin
                        addr   <= {addr[23:0], io.rx_data};
                        rx_cnt <= rx_cnt + 2'd1;
                        if (rx_cnt == 2'd3) begin
                            tout_cnt <= '0;
                            state    <= is_write ? S_WDATA : S_BUS;
                        end
                    end
                end
                S_WDATA: begin
                    if (rx_fire) begin
                        wdata  <= {wdata[23:0], io.rx_data};
                        rx_cnt <= rx_cnt + 2'd1;
                        if (rx_cnt == 2'd3) begin
                            tout_cnt <= '0;
                            state    <= S_BUS;
                        end
                    end
                end
                S_BUS: begin
                    // tout_cnt holds the number of completed req cycles; ack wins in the last one.
                    if (io.bus_ack) begin
                        resp_data <= is_write ? {ACK_BYTE, 24'h0} : io.bus_rdata;
                        resp_cnt  <= is_write ? 3'd1 : 3'd4;
                        tout_cnt  <= '0;
                        state     <= S_RESP;
                    end else if (tout_cnt == TW'(TIMEOUT - 1)) begin
                        resp_data <= {NAK_BYTE, 24'h0};
                        resp_cnt  <= 3'd1;
                        tout_cnt  <= '0;
                        state     <= S_RESP;
                    end else begin
                        tout_cnt <= tout_cnt + TW'(1);
                    end
                end
                S_RESP: begin
                    if (tx_fire) begin
                        resp_data <= {resp_data[23:0], 8'h00};
                        resp_cnt  <= resp_cnt - 3'd1;
                        if (resp_cnt == 3'd1) begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboarded bench for uart_bus_master: commands push expected tx bytes and bus
// transactions; a tx monitor and a bus slave model pop and compare them.
module tb_uart_bus_master;
    localparam int TIMEOUT = 40;

    logic       clk;
    logic       rst;
    logic [2:0] state_dbg;

    uart_bus_master_if u_if ();

    uart_bus_master #(
        .TIMEOUT (TIMEOUT),
        .ACK_BYTE(8'h06),
        .NAK_BYTE(8'h15)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .io       (u_if),
        .state_dbg(state_dbg)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  exp_q[$];
    // {we, addr, wdata, req_len}
    logic [96:0] bus_q[$];

    int          ack_delay   = 0;
    logic [31:0] slave_rdata = 32'h0;
    logic        tx_stall    = 1'b0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // tx ready driver: always ready, or stalled 10 cycles per byte
    int stall_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (!tx_stall) begin
            u_if.tx_ready = 1'b1;
            stall_cnt = 0;
        end else if (u_if.tx_valid && stall_cnt >= 10) begin
            u_if.tx_ready = 1'b1;
            stall_cnt = 0;
        end else begin
            u_if.tx_ready = 1'b0;
            if (u_if.tx_valid) stall_cnt++;
        end
    end

    // tx monitor
    logic       prev_valid = 1'b0;
    logic       prev_hs    = 1'b0;
    logic [7:0] prev_data  = 8'h0;
    always @(negedge clk) begin
        logic hs;
        if (rst) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            hs = u_if.tx_valid && u_if.tx_ready;
            if (u_if.tx_valid) begin
                check("rx_ready_in_resp", 64'(u_if.rx_ready), 64'd0);
                if (prev_valid && !prev_hs) check("tx_stable", 64'(u_if.tx_data), 64'(prev_data));
            end
            if (hs) begin
                check("tx_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) check("tx_byte", 64'(u_if.tx_data), 64'(exp_q.pop_front()));
            end
            prev_valid = u_if.tx_valid;
            prev_data  = u_if.tx_data;
            prev_hs    = hs;
        end
    end

    // bus slave model
    int          req_cycles = 0;
    int          late_cnt   = 0;
    logic [96:0] cur        = '0;
    always @(negedge clk) begin
        if (rst) begin
            req_cycles = 0;
            late_cnt   = 0;
            u_if.bus_ack   = 1'b0;
            u_if.bus_rdata = 32'h0;
        end else if (u_if.bus_req) begin
            req_cycles++;
            if (req_cycles == 1) begin
                check("bus_expected", 64'(bus_q.size() > 0), 64'd1);
                if (bus_q.size() > 0) cur = bus_q.pop_front();
            end
            check("bus_we", 64'(u_if.bus_we), 64'(cur[96]));
            check("bus_addr", 64'(u_if.bus_addr), 64'(cur[95:64]));
            if (cur[96]) check("bus_wdata", 64'(u_if.bus_wdata), 64'(cur[63:32]));
            check("busy_in_bus", 64'(u_if.busy), 64'd1);
            check("rx_ready_in_bus", 64'(u_if.rx_ready), 64'd0);
            if (ack_delay >= 0 && req_cycles == ack_delay + 1) begin
                u_if.bus_ack   = 1'b1;
                u_if.bus_rdata = slave_rdata;
            end else begin
                u_if.bus_ack   = 1'b0;
                u_if.bus_rdata = $urandom;
            end
        end else begin
            if (req_cycles != 0) begin
                check("bus_req_len", 64'(req_cycles), 64'(cur[31:0]));
                if (ack_delay < 0) late_cnt = 5;
                req_cycles = 0;
            end
            u_if.bus_ack   = 1'b0;
            u_if.bus_rdata = 32'h0;
            if (late_cnt > 0) begin
                late_cnt--;
                if (late_cnt == 0) u_if.bus_ack = 1'b1;
            end
        end
    end

    // driver tasks
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(posedge clk);
        #1;
        u_if.rx_data  = b;
        u_if.rx_valid = 1'b1;
        @(negedge clk);
        while (!u_if.rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!u_if.rx_ready) check("rx_accept", 64'(u_if.rx_ready), 64'd1);
        @(posedge clk);
        #1;
        u_if.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic write_cmd(input logic [31:0] a, input logic [31:0] d, input int dly);
        ack_delay = dly;
        bus_q.push_back({1'b1, a & 32'hFFFF_FFFC, d, 32'(dly + 1)});
        exp_q.push_back(8'h06);
        send_byte(8'h57);
        send_word(a);
        send_word(d);
    endtask

    task automatic read_cmd(input logic [31:0] a, input logic [31:0] rd, input int dly);
        ack_delay   = dly;
        slave_rdata = rd;
        bus_q.push_back({1'b0, a & 32'hFFFF_FFFC, 32'h0, (dly < 0) ? 32'(TIMEOUT) : 32'(dly + 1)});
        if (dly < 0) begin
            exp_q.push_back(8'h15);
        end else begin
            for (int i = 3; i >= 0; i--) exp_q.push_back(rd[i*8 +: 8]);
        end
        send_byte(8'h52);
        send_word(a);
    endtask

    task automatic wait_idle();
        logic done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (!u_if.busy && exp_q.size() == 0) done = 1'b1;
        end
        check("drain_done", 64'(done), 64'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, 64'(u_if.rx_ready), 64'd1);
        check({tag, "_tx_valid"}, 64'(u_if.tx_valid), 64'd0);
        check({tag, "_tx_data"}, 64'(u_if.tx_data), 64'd0);
        check({tag, "_bus_req"}, 64'(u_if.bus_req), 64'd0);
        check({tag, "_bus_we"}, 64'(u_if.bus_we), 64'd0);
        check({tag, "_bus_addr"}, 64'(u_if.bus_addr), 64'd0);
        check({tag, "_bus_wdata"}, 64'(u_if.bus_wdata), 64'd0);
        check({tag, "_busy"}, 64'(u_if.busy), 64'd0);
        check({tag, "_state"}, 64'(state_dbg), 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        rst = 1'b1;
        u_if.rx_data  = 8'h0;
        u_if.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // write with ack in the third req cycle
        write_cmd(32'h0000_1004, 32'hDEAD_BEEF, 2);
        wait_idle();
        check("busy_after_write", 64'(u_if.busy), 64'd0);

        // read with same-cycle ack, unaligned address
        read_cmd(32'h0000_1007, 32'h1234_5678, 0);
        wait_idle();

        // timeout followed by a late ack that must be ignored
        read_cmd(32'h0000_2000, 32'h0, -1);
        wait_idle();
        repeat (12) @(negedge clk);
        check("busy_after_late_ack", 64'(u_if.busy), 64'd0);
        check("state_after_late_ack", 64'(state_dbg), 64'd0);
        ack_delay = 0;

        // bad opcode
        exp_q.push_back(8'h15);
        send_byte(8'h41);
        wait_idle();

        // read under tx backpressure
        tx_stall = 1'b1;
        read_cmd(32'h0000_0100, 32'hA1B2_C3D4, 1);
        wait_idle();
        tx_stall = 1'b0;

        // reset mid-command, then a clean write
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h00);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check_reset_values("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        write_cmd(32'hA5A5_0008, 32'h0BAD_F00D, 1);
        wait_idle();

        // random mix
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            d = $urandom;
            if ($urandom_range(0, 1) == 1) write_cmd(a, d, $urandom_range(0, 5));
            else read_cmd(a, d, $urandom_range(0, 5));
            wait_idle();
        end

        repeat (5) @(negedge clk);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        check("bus_q_empty", 64'(bus_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
